// File: rtl/rect_pkg.sv
// Shared types for the rectangle overlay engine: table entry layout and index sizing.
package rect_pkg;

  localparam int unsigned RECT_COORD_W = 10;
  localparam int unsigned RECT_COLOR_W = 12;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] rowstart;
    logic [RECT_COORD_W-1:0] colstart;
    logic [RECT_COORD_W-1:0] width;
    logic [RECT_COORD_W-1:0] length;
    logic [RECT_COLOR_W-1:0] color;
    logic                    enable;
    logic                    blink;
  } rect_entry_t;

  // Index width for an n-entry table, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_hit_cmp.sv
// Combinational containment test of one pixel against one table entry.
module rect_hit_cmp
  import rect_pkg::*;
(
  input  rect_entry_t             entry,
  input  logic [RECT_COORD_W-1:0] row,
  input  logic [RECT_COORD_W-1:0] col,
  input  logic                    blink_phase,
  output logic                    hit
);

  logic [RECT_COORD_W:0] row_end;
  logic [RECT_COORD_W:0] col_end;
  logic                  row_in;
  logic                  col_in;

  // End bounds carry one extra bit so rectangles near the coordinate limit never wrap.
  always_comb begin
    row_end = {1'b0, entry.rowstart} + {1'b0, entry.width};
    col_end = {1'b0, entry.colstart} + {1'b0, entry.length};
    row_in  = (row >= entry.rowstart) && ({1'b0, row} < row_end);
    col_in  = (col >= entry.colstart) && ({1'b0, col} < col_end);
    hit     = entry.enable && (!entry.blink || blink_phase) && row_in && col_in;
  end

endmodule

// File: rtl/rect_overlay_engine.sv
// Double-buffered rectangle table with a 2-stage hit/priority pipeline for streamed pixels.
module rect_overlay_engine
  import rect_pkg::*;
#(
  parameter int unsigned NUM_RECTS    = 32,
  parameter int unsigned COORD_W      = RECT_COORD_W,
  parameter int unsigned COLOR_W      = RECT_COLOR_W,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            pix_row,
  input  logic [COORD_W-1:0]            pix_col,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [idx_w(NUM_RECTS)-1:0]   wr_index,
  input  rect_entry_t                   wr_entry,
  input  logic                          wr_commit,
  output logic                          wr_err,
  output logic                          commit_pending,
  output logic                          out_valid,
  output logic                          out_hit,
  output logic [idx_w(NUM_RECTS)-1:0]   out_index,
  output logic [COLOR_W-1:0]            out_color
);

  localparam int unsigned IW = idx_w(NUM_RECTS);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  rect_entry_t             shadow [NUM_RECTS];
  rect_entry_t             active [NUM_RECTS];
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;

  logic                    swap_c;
  logic                    wr_fire_c;
  logic                    wr_oob_c;
  logic [RECT_COORD_W-1:0] row_c;
  logic [RECT_COORD_W-1:0] col_c;
  logic [NUM_RECTS-1:0]    hit_c;

  logic [NUM_RECTS-1:0]    hit_s1;
  logic                    valid_s1;
  logic [RECT_COLOR_W-1:0] color_s1 [NUM_RECTS];

  logic                    enc_hit;
  logic [IW-1:0]           enc_idx;
  logic [RECT_COLOR_W-1:0] enc_color;

  // Writes are refused in the swap cycle so the copy always sees the pre-write shadow.
  assign swap_c    = frame_start && commit_pending;
  assign wr_ready  = !swap_c;
  assign wr_fire_c = wr_valid && wr_ready;
  assign wr_oob_c  = 32'(wr_index) >= NUM_RECTS;
  assign row_c     = RECT_COORD_W'(pix_row);
  assign col_c     = RECT_COORD_W'(pix_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) shadow[i] <= '0;
    end else if (wr_fire_c && !wr_oob_c) begin
      shadow[wr_index] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) active[i] <= '0;
    end else if (swap_c) begin
      active <= shadow;
    end
  end

  // Commit bookkeeping, write error flag and blink timebase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_pending <= 1'b0;
      wr_err         <= 1'b0;
      blink_cnt      <= '0;
      blink_phase    <= 1'b1;
    end else begin
      commit_pending <= wr_commit || (commit_pending && !frame_start);
      wr_err         <= wr_fire_c && wr_oob_c;
      if (frame_start) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          blink_cnt   <= blink_cnt + BW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_RECTS); g++) begin : g_cmp
    rect_hit_cmp u_cmp (
      .entry       (active[g]),
      .row         (row_c),
      .col         (col_c),
      .blink_phase (blink_phase),
      .hit         (hit_c[g])
    );
  end

  // Colours travel with the hit vector so a swap between S1 and S2 cannot mix tables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_s1   <= '0;
      valid_s1 <= 1'b0;
      for (int i = 0; i < int'(NUM_RECTS); i++) color_s1[i] <= '0;
    end else begin
      hit_s1   <= pix_valid ? hit_c : '0;
      valid_s1 <= pix_valid;
      for (int i = 0; i < int'(NUM_RECTS); i++) color_s1[i] <= active[i].color;
    end
  end

  always_comb begin
    enc_hit   = 1'b0;
    enc_idx   = '0;
    enc_color = '0;
    for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        enc_hit   = 1'b1;
        enc_idx   = IW'(i);
        enc_color = color_s1[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_index <= '0;
      out_color <= '0;
    end else begin
      out_valid <= valid_s1;
      out_hit   <= valid_s1 && enc_hit;
      out_index <= valid_s1 ? enc_idx : '0;
      out_color <= valid_s1 ? COLOR_W'(enc_color) : '0;
    end
  end

endmodule

// File: tb/tb_rect_overlay_engine.sv
// Scoreboard bench for rect_overlay_engine: directed pixels with hand-computed results.
module tb_rect_overlay_engine;
  import rect_pkg::*;

  localparam int unsigned N  = 6;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 10;
  localparam int unsigned KW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_valid;
  logic [CW-1:0] pix_row;
  logic [CW-1:0] pix_col;
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_index;
  rect_entry_t   wr_entry;
  logic          wr_commit;
  logic          wr_err;
  logic          commit_pending;
  logic          out_valid;
  logic          out_hit;
  logic [IW-1:0] out_index;
  logic [KW-1:0] out_color;

  typedef struct {
    int            cyc;
    logic          hit;
    logic [IW-1:0] idx;
    logic [KW-1:0] col;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  rect_overlay_engine #(
    .NUM_RECTS    (N),
    .COORD_W      (CW),
    .COLOR_W      (KW),
    .BLINK_FRAMES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_row        (pix_row),
    .pix_col        (pix_col),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_index       (wr_index),
    .wr_entry       (wr_entry),
    .wr_commit      (wr_commit),
    .wr_err         (wr_err),
    .commit_pending (commit_pending),
    .out_valid      (out_valid),
    .out_hit        (out_hit),
    .out_index      (out_index),
    .out_color      (out_color)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rect_entry_t mk(input int rs, input int cs, input int w, input int l,
                                     input int c, input logic en, input logic bl);
    rect_entry_t e;
    e.rowstart = 10'(rs);
    e.colstart = 10'(cs);
    e.width    = 10'(w);
    e.length   = 10'(l);
    e.color    = 12'(c);
    e.enable   = en;
    e.blink    = bl;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix_drive(input int r, input int c, input logic eh, input int ei, input int ec);
    exp_t e;
    pix_valid = 1'b1;
    pix_row   = 10'(r);
    pix_col   = 10'(c);
    e.cyc = cyc;
    e.hit = eh;
    e.idx = IW'(ei);
    e.col = KW'(ec);
    q.push_back(e);
  endtask

  task automatic pix(input int r, input int c, input logic eh, input int ei, input int ec);
    pix_drive(r, c, eh, ei, ec);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wr(input int idx, input rect_entry_t e);
    wr_valid = 1'b1;
    wr_index = IW'(idx);
    wr_entry = e;
    for (int k = 0; k < 8 && !wr_ready; k++) tick();
    check("wr_ready_before_write", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic frame(input logic cm);
    frame_start = 1'b1;
    wr_commit   = cm;
    tick();
    frame_start = 1'b0;
    wr_commit   = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    repeat (2) tick();
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_commit_pending", int'(commit_pending), 0);
    check("rst_wr_err", int'(wr_err), 0);
    check("rst_out_zero", int'(out_hit) + int'(out_index) + int'(out_color), 0);
    rst = 1'b0;
    tick();
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", int'(out_valid), 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc - e.cyc, 2);
          check("out_hit", int'(out_hit), int'(e.hit));
          check("out_index", int'(out_index), int'(e.idx));
          check("out_color", int'(out_color), int'(e.col));
        end
      end else begin
        check("bubble_zero", int'(out_hit) + int'(out_index) + int'(out_color), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_row = '0; pix_col = '0;
    wr_valid = 1'b0; wr_index = '0; wr_entry = '0; wr_commit = 1'b0;
    do_reset();

    // Empty table
    pix(50, 50, 0, 0, 0);
    drain();

    // Single rectangle: rows 100..279, cols 30..39
    wr(3, mk(100, 30, 180, 10, 'hF00, 1, 0));
    check("wr_err_inrange", int'(wr_err), 0);
    commit();
    check("pending_set", int'(commit_pending), 1);
    frame(0);
    check("pending_clear", int'(commit_pending), 0);
    pix(100, 30, 1, 3, 'hF00);
    pix(279, 39, 1, 3, 'hF00);
    pix(280, 30, 0, 0, 0);
    pix(100, 40, 0, 0, 0);
    pix(99, 30, 0, 0, 0);
    drain();

    // Overlap priority
    wr(1, mk(110, 110, 20, 20, 'h0A0, 1, 0));
    wr(5, mk(115, 115, 10, 10, 'h00B, 1, 0));
    commit();
    frame(0);
    pix(120, 120, 1, 1, 'h0A0);
    pix(112, 112, 1, 1, 'h0A0);
    pix(120, 35, 1, 3, 'hF00);
    drain();

    // Shadow edit is invisible until committed; swap-cycle pixel sees old table
    wr(3, mk(100, 30, 180, 10, 'h0F0, 1, 0));
    frame(0);
    pix(150, 35, 1, 3, 'hF00);
    commit();
    frame_start = 1'b1;
    pix_drive(150, 35, 1, 3, 'hF00);
    tick();
    frame_start = 1'b0;
    pix(150, 35, 1, 3, 'h0F0);
    drain();

    // Write offered during the swap cycle is held and lands in shadow only
    wr(2, mk(0, 0, 5, 5, 'h111, 1, 0));
    commit();
    frame_start = 1'b1;
    wr_valid    = 1'b1;
    wr_index    = 3'd4;
    wr_entry    = mk(0, 10, 5, 5, 'h444, 1, 0);
    #1;
    check("wr_ready_swap", int'(wr_ready), 0);
    tick();
    frame_start = 1'b0;
    #1;
    check("wr_ready_after_swap", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    check("pending_after_swap", int'(commit_pending), 0);
    pix(2, 2, 1, 2, 'h111);
    pix(2, 12, 0, 0, 0);
    commit();
    frame(1);
    check("pending_recommit", int'(commit_pending), 1);
    pix(2, 12, 1, 4, 'h444);
    frame(0);
    check("pending_recommit_clear", int'(commit_pending), 0);
    drain();

    // Out-of-range index
    wr(6, mk(0, 20, 5, 5, 'h666, 1, 0));
    check("wr_err_pulse", int'(wr_err), 1);
    tick();
    check("wr_err_one_cycle", int'(wr_err), 0);
    commit();
    frame(0);
    pix(2, 22, 0, 0, 0);
    pix(2, 2, 1, 2, 'h111);
    drain();

    // Blink with BLINK_FRAMES=2 from a clean reset (counter 0, phase visible)
    do_reset();
    wr(0, mk(300, 300, 10, 10, 'hC0C, 1, 1));
    wr(2, mk(300, 300, 10, 10, 'h2A2, 1, 0));
    commit();
    frame(0);
    pix(305, 305, 1, 0, 'hC0C);
    frame_start = 1'b1;
    pix_drive(305, 305, 1, 0, 'hC0C);
    tick();
    frame_start = 1'b0;
    pix(305, 305, 1, 2, 'h2A2);
    frame(0);
    pix(305, 305, 1, 2, 'h2A2);
    frame(0);
    pix(305, 305, 1, 0, 'hC0C);
    drain();

    // Reset mid-stream: in-flight pixels vanish, tables clear
    pix_drive(305, 305, 1, 0, 'hC0C);
    tick();
    pix_drive(305, 305, 1, 0, 'hC0C);
    tick();
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    q.delete();
    repeat (2) tick();
    check("midrst_out_valid_held", int'(out_valid), 0);
    rst = 1'b0;
    tick();
    pix(305, 305, 0, 0, 0);
    pix(2, 2, 0, 0, 0);
    drain();

    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
